// File: rtl/ps2_byte_rx.sv
`timescale 1ns/1ps
// PS/2 device-to-host byte receiver: input synchronizers, ps2_clk glitch filter, frame FSM.
// Defining PS2_RX_TIMEOUT_EN adds an inter-edge watchdog that aborts a stalled frame.
module ps2_byte_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 22000
) (
   input  logic       clk,
   input  logic       delay_reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   output logic       error
);

   localparam int unsigned   FW        = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_meta, clk_sync, data_meta, data_sync;
   logic          filt_clk, filt_prev, fall;
   logic [FW-1:0] filt_cnt;

   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          parity_q, parity_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          error_q, error_d;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   always_ff @(posedge clk or posedge delay_reset) begin
      if (delay_reset) begin
         clk_meta  <= '1;
         clk_sync  <= '1;
         data_meta <= '1;
         data_sync <= '1;
      end else begin
         clk_meta  <= ps2_clk;
         clk_sync  <= clk_meta;
         data_meta <= ps2_data;
         data_sync <= data_meta;
      end
   end

   // filt_clk follows clk_sync only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or posedge delay_reset) begin
      if (delay_reset) begin
         filt_clk  <= '1;
         filt_prev <= '1;
         filt_cnt  <= '0;
      end else begin
         filt_prev <= filt_clk;
         if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_sync;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_prev & ~filt_clk;

   always_ff @(posedge clk or posedge delay_reset) begin
      if (delay_reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= '0;
         data_q    <= '0;
         valid_q   <= '0;
         error_q   <= '0;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_d     = '0;
`endif
      if (fall) begin
         unique case (state_q)
            IDLE: begin
               bit_cnt_d = '0;
               if (!data_sync) state_d = DATA;
            end
            DATA: begin
               shift_d   = {data_sync, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = data_sync;
               state_d  = STOP;
            end
            STOP: begin
               // Odd parity over data+parity and a high stop bit make a good frame
               if (data_sync && (^{shift_q, parity_q})) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      else if (state_q != IDLE) begin
         if (tmo_q == TMO_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            error_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign error = error_q;

endmodule

// File: tb/tb_ps2_byte_rx.sv
`timescale 1ns/1ps
// Directed and randomized PS/2 frames checked against a frame-level reference model.
module tb_ps2_byte_rx;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 22000;
   localparam int HALF           = 20;

   logic       clk;
   logic       delay_reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data;
   logic       valid;
   logic       error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vcount = 0;
   int ecount = 0;
   int both = 0;
   int last_valid_cyc = 0;
   int last_err_cyc = 0;
   int last_fall_cyc = 0;
   logic [7:0] exp_data;

   ps2_byte_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .delay_reset(delay_reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .data       (data),
      .valid      (valid),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         vcount         <= vcount + 1;
         last_valid_cyc <= cyc;
      end
      if (error === 1'b1) begin
         ecount       <= ecount + 1;
         last_err_cyc <= cyc;
      end
      if (valid === 1'b1 && error === 1'b1) both <= both + 1;
   end

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_ok(input logic [7:0] b, input logic p, input logic s);
      int ones;
      ones = $countones(b) + int'(p);
      return s && (ones % 2 == 1);
   endfunction

   // bits[0] is sent first; glitch_at inserts a 3-clk low pulse in that bit's high phase
   task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b1;
         if (i == glitch_at) begin
            repeat (12) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (5) @(posedge clk);
         end
      end
      repeat (HALF) @(posedge clk);
      #1 ps2_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] b, input logic p, input logic s,
                            input int glitch_at, input string tag);
      int   v0, e0;
      logic ok;
      v0 = vcount;
      e0 = ecount;
      send_bits({s, p, b, 1'b0}, 11, glitch_at);
      repeat (20) @(posedge clk);
      #1;
      ok = frame_ok(b, p, s);
      if (ok) exp_data = b;
      check({tag, "_valid"}, vcount - v0, ok ? 1 : 0);
      check({tag, "_error"}, ecount - e0, ok ? 0 : 1);
      check({tag, "_data"}, data, exp_data);
      if (ok) check({tag, "_latency"}, last_valid_cyc - last_fall_cyc, FILTER_LEN + 3);
   endtask

   task automatic pulse_reset(input string tag);
      @(posedge clk); #1 delay_reset = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, "_rst_data"}, data, 8'h00);
      check({tag, "_rst_valid"}, valid, 1'b0);
      check({tag, "_rst_error"}, error, 1'b0);
      @(posedge clk); #1 delay_reset = 1'b0;
      exp_data = 8'h00;
   endtask

   initial begin
      int v0, e0;
      logic [7:0] b;
      logic pbad, sbad;

      delay_reset = 1'b1;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;
      exp_data    = 8'h00;
      repeat (4) @(negedge clk);
      check("reset_data", data, 8'h00);
      check("reset_valid", valid, 1'b0);
      check("reset_error", error, 1'b0);
      @(posedge clk); #1 delay_reset = 1'b0;
      repeat (10) @(posedge clk);

      run_frame(8'h1C, 1'b0, 1'b1, -1, "good_1c");
      run_frame(8'h5A, 1'b0, 1'b1, -1, "badpar_5a");
      run_frame(8'hF0, 1'b1, 1'b0, -1, "badstop_f0");
      run_frame(8'hF0, 1'b1, 1'b1, -1, "good_f0");
      run_frame(8'h12, 1'b1, 1'b1, 3, "glitch_12");

      // reset in the middle of a frame discards it silently
      v0 = vcount;
      e0 = ecount;
      send_bits({1'b1, 1'b0, 8'hE0, 1'b0}, 5, -1);
      pulse_reset("abort");
      repeat (20) @(posedge clk);
      check("abort_valid", vcount - v0, 0);
      check("abort_error", ecount - e0, 0);
      run_frame(8'hE0, 1'b0, 1'b1, -1, "after_rst_e0");

      for (int k = 0; k < 10; k++) begin
         b    = 8'($urandom);
         pbad = ($urandom_range(0, 3) == 0);
         sbad = ($urandom_range(0, 4) == 0);
         run_frame(b, (~^b) ^ pbad, ~sbad, -1, $sformatf("rand%0d", k));
      end

      // stalled frame: start bit plus 4 data bits, then silence
      v0 = vcount;
      e0 = ecount;
      send_bits({1'b1, 1'b1, 8'h0F, 1'b0}, 5, -1);
`ifdef PS2_RX_TIMEOUT_EN
      for (int k = 0; k < TIMEOUT_CYCLES + 200 && ecount == e0; k++) @(posedge clk);
      repeat (5) @(posedge clk);
      check("tmo_error", ecount - e0, 1);
      check("tmo_valid", vcount - v0, 0);
      check("tmo_window", ((last_err_cyc - last_fall_cyc) >= TIMEOUT_CYCLES) &&
                          ((last_err_cyc - last_fall_cyc) <= TIMEOUT_CYCLES + FILTER_LEN + 4), 1);
`else
      repeat (TIMEOUT_CYCLES + 2000) @(posedge clk);
      check("stall_error", ecount - e0, 0);
      check("stall_valid", vcount - v0, 0);
      pulse_reset("stall");
`endif
      run_frame(8'h12, 1'b1, 1'b1, -1, "after_stall_12");

      check("valid_error_overlap", both, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_byte_rx.md
PS2_BYTE_RX -- requirements
Module: ps2_byte_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, the number of consecutive clk samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 22000, the maximum number of clk cycles allowed between falling edges within a frame (~2 ms at 11 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock (~11 MHz).
REQ-004 SHALL have port delay_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port data, output, 8 bits: last correctly received byte, held until the next good frame.
REQ-008 SHALL have port valid, output, 1 bit: one-clk pulse when data is updated.
REQ-009 SHALL have port error, output, 1 bit: one-clk pulse when a frame is rejected.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-011 SHALL update the filtered clock only after the synchronized ps2_clk has differed from it for FILTER_LEN consecutive clk cycles; a shorter difference resets the count.
REQ-012 SHALL detect a falling edge in the cycle the filtered clock goes 1->0, and sample synchronized ps2_data in that same cycle.
REQ-013 SHALL implement states IDLE, DATA, PARITY and STOP, each advancing only on a falling edge.
REQ-014 SHALL, in IDLE, go to DATA if the sample is 0 (start bit), and otherwise stay in IDLE with no error.
REQ-015 SHALL, in DATA, shift in 8 bits LSB first using a 3-bit bit counter, then go to PARITY after bit 7.
REQ-016 SHALL, in PARITY, capture the parity bit and go to STOP.
REQ-017 SHALL treat a frame as good only if parity is odd (8 data bits plus parity bit contain an odd number of ones) and the stop sample is 1.
REQ-018 SHALL, on a good frame, load data and pulse valid for exactly one clk in the cycle after the stop edge.
REQ-019 SHALL, on a bad frame, pulse error for one clk in the cycle after the stop edge and leave data unchanged.
REQ-020 SHALL return to IDLE after the stop edge whether the frame was good or bad.
REQ-021 SHALL never assert valid and error in the same cycle.
REQ-022 SHALL have a total latency from the stop-bit falling edge on the pin to valid of 2 + FILTER_LEN + 1 clk cycles.
REQ-023 SHALL hold valid and error low in all other cycles; there is no back-pressure, so consumers latch data on valid.

Reset
REQ-024 SHALL, while delay_reset is high, force: synchronizers and filtered clock = 1, state = IDLE, counters = 0, data = 8'h00, valid = 0, error = 0.
REQ-025 SHALL discard a partially received frame if reset asserts mid-frame, with no valid or error pulse; reception restarts at the next start bit after release.

Configuration
REQ-026 SHALL, with PS2_RX_TIMEOUT_EN defined, keep a counter cleared on every falling edge and incremented every clk while state is not IDLE.
REQ-027 SHALL, with PS2_RX_TIMEOUT_EN defined, return to IDLE and pulse error once when that counter reaches TIMEOUT_CYCLES.
REQ-028 SHALL, without PS2_RX_TIMEOUT_EN, omit the counter entirely, so an incomplete frame waits indefinitely for further edges.

Verification
REQ-029 SHALL cover: frame 0x1C with parity 0 and stop 1 -> data=0x1C, valid high for exactly one clk, error never high.
REQ-030 SHALL cover: frame 0x5A with parity 0 (wrong) -> error pulses once, valid stays 0, data keeps its previous value 0x1C.
REQ-031 SHALL cover: frame 0xF0 with parity 1 but stop 0 -> error pulses once; a following good 0xF0 frame -> data=0xF0, valid pulses.
REQ-032 SHALL cover: 3-clk low glitch on ps2_clk with FILTER_LEN=8 during DATA -> no bit consumed; a subsequent good 0x12 frame -> data=0x12.
REQ-033 SHALL cover, with PS2_RX_TIMEOUT_EN: start bit plus 4 bits, then idle -> error pulses 22000 clk after the last edge; a following good 0x12 frame -> valid, data=0x12.
REQ-034 SHALL cover: delay_reset pulsed after 5 bits, then a full 0xE0 frame with parity 0 -> no pulse from the aborted frame, data=0xE0 with one valid pulse.
